u74hc193: RTL and testbench

U74HC193 -- requirements
Module: u74hc193

---
 rtl/u74hc193_pkg.sv | 29 ++
 rtl/u74hc193_pin_edge.sv | 32 +++
 rtl/u74hc193.sv | 100 ++++++++++
 tb/tb_u74hc193.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/u74hc193_pkg.sv
// Shared 74HC component package: count width, count-direction ops and
// nominal propagation delays used when this part sits in a board netlist.
package u74hc193_pkg;

    localparam int COUNT_W = 4;
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    // Nominal 74HC timing at 5 V in ns, consumed only by simulation models
    localparam int DEFAULT_DELAY_NS = 18;
    localparam int HC00_TPD_NS      = 7;
    localparam int HC74_TPD_NS      = 14;
    localparam int HC193_TPD_NS     = DEFAULT_DELAY_NS;

    // What the counter does to its value on a given cycle
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_LOAD,
        OP_UP,
        OP_DOWN
    } count_op_e;

    // Modulo-16 step in either direction; wraps naturally through the 4-bit width
    function automatic logic [COUNT_W-1:0] count_step(input logic [COUNT_W-1:0] q,
                                                       input logic dir_up);
        return dir_up ? q + 1'b1 : q - 1'b1;
    endfunction

endpackage

// File: rtl/u74hc193_pin_edge.sv
// Registered sample of one count pin plus its rising-edge detect.
// The sample resets high so a pin already high when reset releases is not
// mistaken for an edge; a genuine low sample is needed first.
module pin_edge (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic pin_p,
    output logic rise
);

    logic sample_q;
    logic sample_d;

    // The stored sample follows the pin every cycle, even while clr or load are active
    always_comb begin
        sample_d = pin;
    end

    // Previous-sample register
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_q <= 1'b1;
        end else begin
            sample_q <= sample_d;
        end
    end

    assign pin_p = sample_q;
    assign rise  = pin & ~sample_q;

endmodule

// File: rtl/u74hc193.sv
// Synchronous model of the 74HC193 4-bit up/down counter.
// Counting happens on a sampled rising edge of one count pin while the other
// pin is held high; carry/borrow are decoded from registered state only.
module u74hc193
    import u74hc193_pkg::*;
#(
    parameter logic [COUNT_W-1:0] ic    = '0,
    parameter int                 delay = DEFAULT_DELAY_NS
) (
    input  logic clk,
    input  logic rst,
    input  logic vcc,
    input  logic gnd,
    input  logic up,
    input  logic down,
    input  logic clr,
    input  logic load_n,
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic qa,
    output logic qb,
    output logic qc,
    output logic qd,
    output logic co_n,
    output logic bo_n
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;
    logic [COUNT_W-1:0] load_val;
    count_op_e          op;
    logic               up_p;
    logic               up_rise;
    logic               down_p;
    logic               down_rise;

    // Supply pins and the transport delay only matter to a netlist simulator
    logic [31:0] unused_cfg;
    assign unused_cfg = {delay[29:0], vcc, gnd};

    pin_edge u_up_edge (
        .clk   (clk),
        .rst   (rst),
        .pin   (up),
        .pin_p (up_p),
        .rise  (up_rise)
    );

    pin_edge u_down_edge (
        .clk   (clk),
        .rst   (rst),
        .pin   (down),
        .pin_p (down_p),
        .rise  (down_rise)
    );

    assign load_val = {d, c, b, a};

    // Pick this cycle's operation: clear beats load beats counting; simultaneous edges cancel
    always_comb begin
        op = OP_HOLD;
        if (clr) begin
            op = OP_CLEAR;
        end else if (!load_n) begin
            op = OP_LOAD;
        end else if (up_rise && !down_rise && down) begin
            op = OP_UP;
        end else if (down_rise && !up_rise && up) begin
            op = OP_DOWN;
        end
    end

    // Next count value for the chosen operation
    always_comb begin
        count_d = count_q;
        case (op)
            OP_CLEAR: count_d = '0;
            OP_LOAD:  count_d = load_val;
            OP_UP:    count_d = count_step(count_q, 1'b1);
            OP_DOWN:  count_d = count_step(count_q, 1'b0);
            default:  count_d = count_q;
        endcase
    end

    // Count register; reset loads the configured initial count
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= ic;
        end else begin
            count_q <= count_d;
        end
    end

    assign {qd, qc, qb, qa} = count_q;
    assign co_n = ~((count_q == COUNT_MAX) & ~up_p);
    assign bo_n = ~((count_q == '0) & ~down_p);

endmodule

// File: tb/tb_u74hc193.sv
// Bench for u74hc193: two instances (initial count 5 and 0) share all inputs.
// A behavioural model tracks both counts with integer arithmetic and is
// compared against the outputs every falling edge; directed sequences add
// hand-computed literal checks.
module tb_u74hc193;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic up = 1'b1;
    logic down = 1'b1;
    logic clr = 1'b0;
    logic load_n = 1'b1;
    logic a = 1'b0;
    logic b = 1'b0;
    logic c = 1'b0;
    logic d = 1'b0;

    logic qa_5, qb_5, qc_5, qd_5, co_n_5, bo_n_5;
    logic qa_0, qb_0, qc_0, qd_0, co_n_0, bo_n_0;

    int vectors = 0;
    int miscompares = 0;

    int  m_q5 = 0;
    int  m_q0 = 0;
    bit  m_up_p = 1'b1;
    bit  m_dn_p = 1'b1;
    bit  model_valid = 1'b0;

    always #5 clk = ~clk;

    u74hc193 #(.ic(4'd5)) dut_ic5 (
        .clk(clk), .rst(rst), .vcc(1'b1), .gnd(1'b0),
        .up(up), .down(down), .clr(clr), .load_n(load_n),
        .a(a), .b(b), .c(c), .d(d),
        .qa(qa_5), .qb(qb_5), .qc(qc_5), .qd(qd_5),
        .co_n(co_n_5), .bo_n(bo_n_5)
    );

    u74hc193 #(.ic(4'd0)) dut_ic0 (
        .clk(clk), .rst(rst), .vcc(1'b1), .gnd(1'b0),
        .up(up), .down(down), .clr(clr), .load_n(load_n),
        .a(a), .b(b), .c(c), .d(d),
        .qa(qa_0), .qb(qb_0), .qc(qc_0), .qd(qd_0),
        .co_n(co_n_0), .bo_n(bo_n_0)
    );

    // Compare one observed value against its expectation
    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Step a count by the rules of the part: returns the next value
    function automatic int next_count(input int q, input bit up_edge, input bit dn_edge,
                                      input int load_value);
        if (clr) return 0;
        if (!load_n) return load_value;
        if (up_edge && !dn_edge && down) return (q + 1) % 16;
        if (dn_edge && !up_edge && up) return (q + 15) % 16;
        return q;
    endfunction

    // Behavioural model, advanced on every rising edge from the sampled inputs
    always @(posedge clk) begin
        bit ue;
        bit de;
        int lv;
        if (rst) begin
            m_q5 = 5;
            m_q0 = 0;
            m_up_p = 1'b1;
            m_dn_p = 1'b1;
            model_valid = 1'b1;
        end else begin
            ue = up && !m_up_p;
            de = down && !m_dn_p;
            lv = 8 * int'(d) + 4 * int'(c) + 2 * int'(b) + int'(a);
            m_q5 = next_count(m_q5, ue, de, lv);
            m_q0 = next_count(m_q0, ue, de, lv);
            m_up_p = up;
            m_dn_p = down;
        end
    end

    // Every falling edge, both instances are checked against the model
    always @(negedge clk) begin
        if (model_valid) begin
            checkOutput("q_ic5", int'({qd_5, qc_5, qb_5, qa_5}), m_q5);
            checkOutput("co_n_ic5", int'(co_n_5), (m_q5 == 15 && !m_up_p) ? 0 : 1);
            checkOutput("bo_n_ic5", int'(bo_n_5), (m_q5 == 0 && !m_dn_p) ? 0 : 1);
            checkOutput("q_ic0", int'({qd_0, qc_0, qb_0, qa_0}), m_q0);
            checkOutput("co_n_ic0", int'(co_n_0), (m_q0 == 15 && !m_up_p) ? 0 : 1);
            checkOutput("bo_n_ic0", int'(bo_n_0), (m_q0 == 0 && !m_dn_p) ? 0 : 1);
        end
    end

    // Drive one cycle of inputs, then return just after the edge that samples them
    task automatic applyStimulus(input logic r, input logic u, input logic dn,
                                 input logic cl, input logic ld_n, input logic [3:0] data);
        rst = r;
        up = u;
        down = dn;
        clr = cl;
        load_n = ld_n;
        {d, c, b, a} = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset: ic=5 instance comes up at 5, ic=0 instance at 0, flags inactive
        applyStimulus(1, 1, 1, 0, 1, 4'd0);
        checkOutput("lit_reset_q5", int'({qd_5, qc_5, qb_5, qa_5}), 5);
        checkOutput("lit_reset_co5", int'(co_n_5), 1);
        checkOutput("lit_reset_bo5", int'(bo_n_5), 1);
        checkOutput("lit_reset_q0", int'({qd_0, qc_0, qb_0, qa_0}), 0);
        checkOutput("lit_reset_bo0", int'(bo_n_0), 1);

        // Up wrap from 14 with down held high
        applyStimulus(0, 1, 1, 0, 0, 4'd14);
        checkOutput("lit_load14", int'({qd_5, qc_5, qb_5, qa_5}), 14);
        applyStimulus(0, 0, 1, 0, 1, 4'd0);
        checkOutput("lit_14_up_low_co", int'(co_n_5), 1);
        applyStimulus(0, 1, 1, 0, 1, 4'd0);
        checkOutput("lit_up_to15", int'({qd_5, qc_5, qb_5, qa_5}), 15);
        checkOutput("lit_15_up_high_co", int'(co_n_5), 1);
        applyStimulus(0, 0, 1, 0, 1, 4'd0);
        checkOutput("lit_15_up_low_co", int'(co_n_5), 0);
        applyStimulus(0, 1, 1, 0, 1, 4'd0);
        checkOutput("lit_up_wrap0", int'({qd_0, qc_0, qb_0, qa_0}), 0);
        checkOutput("lit_wrap_co", int'(co_n_0), 1);

        // Down wrap from 0 with up held high
        applyStimulus(0, 1, 0, 0, 1, 4'd0);
        checkOutput("lit_0_down_low_bo", int'(bo_n_0), 0);
        applyStimulus(0, 1, 1, 0, 1, 4'd0);
        checkOutput("lit_down_wrap15", int'({qd_0, qc_0, qb_0, qa_0}), 15);
        checkOutput("lit_down_wrap_bo", int'(bo_n_0), 1);

        // Priority: clr over load over an up edge; abcd = 1010 loads 5
        applyStimulus(0, 0, 1, 0, 1, 4'd0);
        applyStimulus(0, 1, 1, 1, 0, 4'b0101);
        checkOutput("lit_clr_wins", int'({qd_5, qc_5, qb_5, qa_5}), 0);
        applyStimulus(0, 1, 1, 0, 0, 4'b0101);
        checkOutput("lit_load_after_clr", int'({qd_5, qc_5, qb_5, qa_5}), 5);
        applyStimulus(0, 1, 1, 0, 1, 4'b0101);
        checkOutput("lit_no_count_on_release", int'({qd_5, qc_5, qb_5, qa_5}), 5);

        // Simultaneous edges cancel; up edge with down low does nothing
        applyStimulus(0, 1, 1, 0, 0, 4'd7);
        applyStimulus(0, 0, 0, 0, 1, 4'd7);
        applyStimulus(0, 1, 1, 0, 1, 4'd7);
        checkOutput("lit_both_edges_hold", int'({qd_5, qc_5, qb_5, qa_5}), 7);
        applyStimulus(0, 0, 0, 0, 1, 4'd7);
        applyStimulus(0, 1, 0, 0, 1, 4'd7);
        checkOutput("lit_up_down_low_hold", int'({qd_5, qc_5, qb_5, qa_5}), 7);

        // Reset between the low and high up samples discards the edge
        applyStimulus(0, 1, 1, 0, 0, 4'd9);
        applyStimulus(0, 0, 1, 0, 1, 4'd9);
        checkOutput("lit_at9", int'({qd_0, qc_0, qb_0, qa_0}), 9);
        applyStimulus(1, 1, 1, 0, 1, 4'd9);
        checkOutput("lit_rst_mid_q0", int'({qd_0, qc_0, qb_0, qa_0}), 0);
        applyStimulus(0, 1, 1, 0, 1, 4'd9);
        checkOutput("lit_rst_edge_dropped", int'({qd_0, qc_0, qb_0, qa_0}), 0);

        // Randomised traffic with occasional reset, clear and load
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          ($urandom_range(0, 15) == 0),
                          ($urandom_range(0, 7) != 0),
                          4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
